// File: rtl/matmul_pkg.sv
// Shared register map, status bit positions and controller state encoding
// for the matrix-multiply MMIO controller.
package matmul_pkg;

  localparam logic [11:0] CTRL_OFF   = 12'h000;
  localparam logic [11:0] STATUS_OFF = 12'h004;
  localparam logic [11:0] CYCLES_OFF = 12'h008;
  localparam logic [11:0] A_BASE     = 12'h100;
  localparam logic [11:0] B_BASE     = 12'h200;
  localparam logic [11:0] C_BASE     = 12'h300;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_TIMEOUT = 2;
  localparam int unsigned ST_WR_ERR  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/mmio_regfile_dec.sv
// Bus address decode into write strobes, plus the registered read mux and
// the one-cycle acknowledge.
module mmio_regfile_dec
  import matmul_pkg::*;
#(
  parameter int EW = 16,
  parameter int NA = 4,
  parameter int NB = 4,
  parameter int NC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bus_we_i,
  input  logic               bus_re_i,
  input  logic [11:0]        bus_addr_i,
  output logic [31:0]        bus_rdata_o,
  output logic               bus_ready_o,
  output logic               ctrl_wr_o,
  output logic               status_wr_o,
  output logic               a_wr_o,
  output logic               b_wr_o,
  output logic [5:0]         idx_o,
  input  logic [31:0]        ctrl_rd_i,
  input  logic [31:0]        status_rd_i,
  input  logic [31:0]        cycles_i,
  input  logic [NA*EW-1:0]   a_flat_i,
  input  logic [NB*EW-1:0]   b_flat_i,
  input  logic [NC*2*EW-1:0] c_flat_i
);

  logic [11:0] addr_s;
  logic [5:0]  word_s;
  logic        a_hit_s, b_hit_s, c_hit_s;
  logic [31:0] rdata_d, rdata_q;
  logic        ready_q;
  logic        unused_s;

  assign addr_s   = {bus_addr_i[11:2], 2'b00};
  assign word_s   = bus_addr_i[7:2];
  assign idx_o    = word_s;
  assign unused_s = ^bus_addr_i[1:0];

  assign a_hit_s = (addr_s[11:8] == A_BASE[11:8]) && (int'(word_s) < NA);
  assign b_hit_s = (addr_s[11:8] == B_BASE[11:8]) && (int'(word_s) < NB);
  assign c_hit_s = (addr_s[11:8] == C_BASE[11:8]) && (int'(word_s) < NC);

  assign ctrl_wr_o   = bus_we_i && (addr_s == CTRL_OFF);
  assign status_wr_o = bus_we_i && (addr_s == STATUS_OFF);
  assign a_wr_o      = bus_we_i && a_hit_s;
  assign b_wr_o      = bus_we_i && b_hit_s;

  // Read mux; a read colliding with a write returns zero.
  always_comb begin
    rdata_d = 32'd0;
    if (bus_re_i && !bus_we_i) begin
      if (addr_s == CTRL_OFF)        rdata_d = ctrl_rd_i;
      else if (addr_s == STATUS_OFF) rdata_d = status_rd_i;
      else if (addr_s == CYCLES_OFF) rdata_d = cycles_i;
      else if (a_hit_s)              rdata_d = 32'(a_flat_i[int'(word_s)*EW +: EW]);
      else if (b_hit_s)              rdata_d = 32'(b_flat_i[int'(word_s)*EW +: EW]);
      else if (c_hit_s)              rdata_d = 32'(c_flat_i[int'(word_s)*2*EW +: 2*EW]);
      else                           rdata_d = 32'd0;
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Registered read data and acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ready_q <= bus_we_i | bus_re_i;
    end
  end

  assign bus_rdata_o = rdata_q;
  assign bus_ready_o = ready_q;

endmodule

// File: rtl/matmul_mmio_ctrl.sv
// MMIO initiator for the systolic matmul engine: operand/result buffers,
// control/status registers and the start/wait/capture sequencer.
module matmul_mmio_ctrl
  import matmul_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 16,
  parameter int ROW_A         = 2,
  parameter int COL_A         = 2,
  parameter int COL_B         = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_we,
  input  logic                       bus_re,
  input  logic [11:0]                bus_addr,
  input  logic [31:0]                bus_wdata,
  output logic [31:0]                bus_rdata,
  output logic                       bus_ready,
  output logic                       irq,
  output logic [ELEMENT_WIDTH-1:0]   mat_a [0:ROW_A-1][0:COL_A-1],
  output logic [ELEMENT_WIDTH-1:0]   mat_b [0:COL_A-1][0:COL_B-1],
  output logic                       initiate_compute,
  input  logic                       compute_done,
  input  logic [2*ELEMENT_WIDTH-1:0] res_matrix [0:ROW_A-1][0:COL_B-1]
);

  localparam int EW = ELEMENT_WIDTH;
  localparam int NA = ROW_A * COL_A;
  localparam int NB = COL_A * COL_B;
  localparam int NC = ROW_A * COL_B;

  state_e        state_q, state_d;
  logic [EW-1:0] a_q [NA];
  logic [EW-1:0] b_q [NB];
  logic [2*EW-1:0] c_q [NC];
  logic          irq_en_q, done_q, timeout_q, wr_err_q, first_wait_q;
  logic [31:0]   cnt_q, cycles_q;

  logic          ctrl_wr_s, status_wr_s, a_wr_s, b_wr_s;
  logic [5:0]    idx_s;
  logic [31:0]   ctrl_rd_s, status_rd_s;
  logic [NA*EW-1:0]   a_flat_s;
  logic [NB*EW-1:0]   b_flat_s;
  logic [NC*2*EW-1:0] c_flat_s;
  logic          start_s, done_ok_s, timeout_hit_s;
  logic          busy_s, initiate_s, capture_s, timeout_evt_s;
  logic          unused_s;

  assign unused_s      = ^bus_wdata[31:EW];
  assign start_s       = ctrl_wr_s && bus_wdata[CTRL_START] && (state_q == S_IDLE);
  // The first WAIT cycle may still see the previous run's done level.
  assign done_ok_s     = !first_wait_q && compute_done;
  assign timeout_hit_s = (cnt_q >= 32'(TIMEOUT));

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_s) state_d = S_START; else state_d = S_IDLE;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (done_ok_s)          state_d = S_CAPTURE;
        else if (timeout_hit_s) state_d = S_IDLE;
        else                    state_d = S_WAIT;
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs.
  always_comb begin
    busy_s        = 1'b0;
    initiate_s    = 1'b0;
    capture_s     = 1'b0;
    timeout_evt_s = 1'b0;
    case (state_q)
      S_IDLE:    busy_s = 1'b0;
      S_START:   begin busy_s = 1'b1; initiate_s = 1'b1; end
      S_WAIT:    begin busy_s = 1'b1; timeout_evt_s = !done_ok_s && timeout_hit_s; end
      S_CAPTURE: begin busy_s = 1'b1; capture_s = 1'b1; end
      default:   busy_s = 1'b0;
    endcase
  end

  // Control, sticky status flags, run counter and CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      first_wait_q <= 1'b0;
      cnt_q        <= 32'd0;
      cycles_q     <= 32'd0;
    end else begin
      first_wait_q <= (state_q == S_START);
      if (ctrl_wr_s) irq_en_q <= bus_wdata[CTRL_IRQ_EN];
      if (capture_s) done_q <= 1'b1;
      else if (start_s || (status_wr_s && bus_wdata[ST_DONE])) done_q <= 1'b0;
      if (timeout_evt_s) timeout_q <= 1'b1;
      else if (start_s || (status_wr_s && bus_wdata[ST_TIMEOUT])) timeout_q <= 1'b0;
      if ((a_wr_s || b_wr_s) && busy_s) wr_err_q <= 1'b1;
      else if (status_wr_s && bus_wdata[ST_WR_ERR]) wr_err_q <= 1'b0;
      if (start_s) cnt_q <= 32'd0;
      else if (((state_q == S_START) || (state_q == S_WAIT)) && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
      if (capture_s) cycles_q <= cnt_q;
    end
  end

  // Operand buffers (frozen while busy) and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NA; k++) a_q[k] <= '0;
      for (int k = 0; k < NB; k++) b_q[k] <= '0;
      for (int k = 0; k < NC; k++) c_q[k] <= '0;
    end else begin
      for (int k = 0; k < NA; k++)
        if (a_wr_s && !busy_s && (idx_s == 6'(k))) a_q[k] <= bus_wdata[EW-1:0];
      for (int k = 0; k < NB; k++)
        if (b_wr_s && !busy_s && (idx_s == 6'(k))) b_q[k] <= bus_wdata[EW-1:0];
      if (capture_s)
        for (int r = 0; r < ROW_A; r++)
          for (int c = 0; c < COL_B; c++)
            c_q[r*COL_B+c] <= res_matrix[r][c];
    end
  end

  // Register read views.
  always_comb begin
    ctrl_rd_s                = 32'd0;
    ctrl_rd_s[CTRL_IRQ_EN]   = irq_en_q;
    status_rd_s              = 32'd0;
    status_rd_s[ST_BUSY]     = busy_s;
    status_rd_s[ST_DONE]     = done_q;
    status_rd_s[ST_TIMEOUT]  = timeout_q;
    status_rd_s[ST_WR_ERR]   = wr_err_q;
  end

  for (genvar r = 0; r < ROW_A; r++) begin : g_a_row
    for (genvar c = 0; c < COL_A; c++) begin : g_a_col
      assign mat_a[r][c] = a_q[r*COL_A+c];
    end
  end
  for (genvar r = 0; r < COL_A; r++) begin : g_b_row
    for (genvar c = 0; c < COL_B; c++) begin : g_b_col
      assign mat_b[r][c] = b_q[r*COL_B+c];
    end
  end
  for (genvar k = 0; k < NA; k++) begin : g_a_flat
    assign a_flat_s[k*EW +: EW] = a_q[k];
  end
  for (genvar k = 0; k < NB; k++) begin : g_b_flat
    assign b_flat_s[k*EW +: EW] = b_q[k];
  end
  for (genvar k = 0; k < NC; k++) begin : g_c_flat
    assign c_flat_s[k*2*EW +: 2*EW] = c_q[k];
  end

  assign initiate_compute = initiate_s;
  assign irq              = done_q & irq_en_q;

  mmio_regfile_dec #(.EW(EW), .NA(NA), .NB(NB), .NC(NC)) u_dec (
    .clk         (clk),
    .reset       (reset),
    .bus_we_i    (bus_we),
    .bus_re_i    (bus_re),
    .bus_addr_i  (bus_addr),
    .bus_rdata_o (bus_rdata),
    .bus_ready_o (bus_ready),
    .ctrl_wr_o   (ctrl_wr_s),
    .status_wr_o (status_wr_s),
    .a_wr_o      (a_wr_s),
    .b_wr_o      (b_wr_s),
    .idx_o       (idx_s),
    .ctrl_rd_i   (ctrl_rd_s),
    .status_rd_i (status_rd_s),
    .cycles_i    (cycles_q),
    .a_flat_i    (a_flat_s),
    .b_flat_i    (b_flat_s),
    .c_flat_i    (c_flat_s)
  );

endmodule
